// File: rtl/cpu_request_queue_if.sv
// Handshake and command bundle for cpu_request_queue.
//
// Groups three channels that all meet at the queue:
//   req_*                       : requester -> queue, valid/ready, with req_ready = !full
//   cpu_* / done / hit / miss   : queue -> cache subsystem command, subsystem -> queue status
//   rsp_*                       : queue -> consumer, valid/ready
//
// Modports:
//   slave  : the queue itself
//   master : the surrounding environment (requester, cache subsystem and response consumer)
interface cpu_request_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_wdata;

  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cache_hit;
  logic              cache_miss;
  logic              done_signal;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_miss;

  modport slave (
    input  req_valid, req_write, req_address, req_wdata,
    output req_ready,
    output cpu_read, cpu_write, cpu_address, cpu_write_data,
    input  cpu_read_data, cache_hit, cache_miss, done_signal,
    output rsp_valid, rsp_write, rsp_rdata, rsp_miss,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_write, req_address, req_wdata,
    input  req_ready,
    input  cpu_read, cpu_write, cpu_address, cpu_write_data,
    output cpu_read_data, cache_hit, cache_miss, done_signal,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_miss,
    output rsp_ready
  );
endinterface

// File: rtl/cpu_request_queue.sv
// cpu_request_queue
//
// Buffers CPU read/write requests in a small FIFO and issues them one at a
// time to the cache subsystem. Each issued command is held until the
// subsystem pulses done_signal; the result (read data, write flag, miss flag)
// is then offered on the response channel. Only one transaction is ever
// outstanding: the next head entry is not issued until the response is taken.
// Saturating counters track completions with and without a miss.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : cpu_request_queue_if.slave (request, command and response channels)
//   hit_count  : completed transactions without a miss, saturating
//   miss_count : completed transactions with a miss, saturating
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no command on the bus; waiting for the FIFO to hold an entry
// ISSUE | head entry driven on cpu_*; waiting for done_signal
// RESP  | response held on rsp_*; waiting for rsp_ready
module cpu_request_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_request_queue_if.slave   bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // FIFO storage; contents are not reset because the pointers and count
  // alone decide which entries are live.
  logic              fifo_write [DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic [DATA_W-1:0] fifo_data  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              full;
  logic              push;
  logic              pop;
  logic              issuing;
  logic              head_write;

  logic              miss_sticky;
  logic              txn_miss;

  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_miss_q;

  // Hit status is implied by the absence of a miss, so cache_hit is not needed.
  logic              unused_cache_hit;
  assign unused_cache_hit = bus.cache_hit;

  assign full       = (count == FULL_CNT);
  assign issuing    = (state_q == ST_ISSUE);
  // Push is gated on the registered count only, so a pop in the same cycle
  // does not make room for a push into a full FIFO.
  assign push       = bus.req_valid && !full;
  assign pop        = issuing && bus.done_signal;
  assign head_write = fifo_write[rd_ptr];
  assign txn_miss   = miss_sticky | bus.cache_miss;

  assign bus.req_ready = !full;

  // FIFO data path
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_addr[wr_ptr]  <= bus.req_address;
      fifo_data[wr_ptr]  <= bus.req_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.done_signal) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command outputs decode straight from the state register and FIFO head,
  // so they are stable for the whole ISSUE residency.
  always_comb begin
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b0;
    bus.cpu_address    = '0;
    bus.cpu_write_data = '0;
    if (issuing) begin
      bus.cpu_read       = !head_write;
      bus.cpu_write      = head_write;
      bus.cpu_address    = fifo_addr[rd_ptr];
      bus.cpu_write_data = fifo_data[rd_ptr];
    end
  end

  // A miss may be reported on any cycle of the transaction, not only with
  // done_signal, so it is remembered until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_sticky <= 1'b0;
    end else if (pop) begin
      miss_sticky <= 1'b0;
    end else if (issuing && bus.cache_miss) begin
      miss_sticky <= 1'b1;
    end
  end

  // Response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_miss_q  <= 1'b0;
    end else if (pop) begin
      rsp_write_q <= head_write;
      rsp_rdata_q <= head_write ? '0 : bus.cpu_read_data;
      rsp_miss_q  <= txn_miss;
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_miss  = rsp_miss_q;

  // Saturating completion counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (pop) begin
      if (txn_miss) begin
        if (miss_count != '1) begin
          miss_count <= miss_count + CNT_W'(1);
        end
      end else begin
        if (hit_count != '1) begin
          hit_count <= hit_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_request_queue.sv
// Directed bench for cpu_request_queue. A second instance with 4-bit counters
// sees identical traffic so counter saturation is reached in a few cycles.
module tb_cpu_request_queue;

  localparam logic [511:0] DATA_A5 = {64{8'hA5}};
  localparam logic [511:0] DATA_5A = {64{8'h5A}};
  localparam logic [511:0] DATA_FF = {64{8'hFF}};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [3:0]  sat_hit_count;
  logic [3:0]  sat_miss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_request_queue_if #(.ADDR_W(32), .DATA_W(512)) bus ();
  cpu_request_queue_if #(.ADDR_W(32), .DATA_W(512)) sat_bus ();

  assign sat_bus.req_valid     = bus.req_valid;
  assign sat_bus.req_write     = bus.req_write;
  assign sat_bus.req_address   = bus.req_address;
  assign sat_bus.req_wdata     = bus.req_wdata;
  assign sat_bus.cpu_read_data = bus.cpu_read_data;
  assign sat_bus.cache_hit     = bus.cache_hit;
  assign sat_bus.cache_miss    = bus.cache_miss;
  assign sat_bus.done_signal   = bus.done_signal;
  assign sat_bus.rsp_ready     = bus.rsp_ready;

  cpu_request_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(512), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  cpu_request_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(512), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .bus        (sat_bus),
    .hit_count  (sat_hit_count),
    .miss_count (sat_miss_count)
  );

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [511:0] d);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_address = a;
    bus.req_wdata   = d;
    step();
    bus.req_valid   = 1'b0;
  endtask

  task automatic finish_txn(input logic [511:0] rd, input logic miss);
    bus.done_signal   = 1'b1;
    bus.cpu_read_data = rd;
    bus.cache_miss    = miss;
    bus.cache_hit     = !miss;
    step();
    bus.done_signal   = 1'b0;
    bus.cache_miss    = 1'b0;
    bus.cache_hit     = 1'b0;
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  function automatic logic [511:0] pat(input logic [31:0] a);
    return {16{a}};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill_addr [4];
    fill_addr[0] = 32'h200;
    fill_addr[1] = 32'h300;
    fill_addr[2] = 32'h400;
    fill_addr[3] = 32'h500;

    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_address   = '0;
    bus.req_wdata     = '0;
    bus.cpu_read_data = '0;
    bus.cache_hit     = 1'b0;
    bus.cache_miss    = 1'b0;
    bus.done_signal   = 1'b0;
    bus.rsp_ready     = 1'b0;

    // Reset values
    step();
    step();
    check_val("rst_req_ready", bus.req_ready, 1);
    check_val("rst_cpu_read", bus.cpu_read, 0);
    check_val("rst_cpu_write", bus.cpu_write, 0);
    check_val("rst_cpu_address", bus.cpu_address, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_val("rst_hit_count", hit_count, 0);
    check_val("rst_miss_count", miss_count, 0);
    rst = 1'b0;
    step();

    // Single read with a miss reported mid-transaction only
    push(1'b0, 32'h40, '0);
    check_val("t1_idle_no_cmd", bus.cpu_read, 0);
    step();
    check_val("t1_cpu_read", bus.cpu_read, 1);
    check_val("t1_cpu_write", bus.cpu_write, 0);
    check_val("t1_cpu_address", bus.cpu_address, 32'h40);
    for (int i = 0; i < 9; i++) begin
      bus.cache_miss = (i == 4);
      step();
    end
    bus.cache_miss = 1'b0;
    check_val("t1_cpu_read_held", bus.cpu_read, 1);
    check_val("t1_addr_held", bus.cpu_address, 32'h40);
    finish_txn(DATA_A5, 1'b0);
    check_val("t1_rsp_valid", bus.rsp_valid, 1);
    check_val("t1_rsp_rdata", bus.rsp_rdata, DATA_A5);
    check_val("t1_rsp_miss", bus.rsp_miss, 1);
    check_val("t1_rsp_write", bus.rsp_write, 0);
    check_val("t1_miss_count", miss_count, 1);
    check_val("t1_hit_count", hit_count, 0);
    check_val("t1_cmd_dropped", bus.cpu_read, 0);
    consume();
    check_val("t1_rsp_taken", bus.rsp_valid, 0);

    // Write then read, second completes in its first command cycle
    push(1'b1, 32'h40, 512'h1234);
    push(1'b0, 32'h40, '0);
    check_val("t2_cpu_write", bus.cpu_write, 1);
    check_val("t2_cpu_read_low", bus.cpu_read, 0);
    check_val("t2_wdata", bus.cpu_write_data, 512'h1234);
    check_val("t2_addr", bus.cpu_address, 32'h40);
    finish_txn(DATA_FF, 1'b0);
    check_val("t2_wr_rsp_write", bus.rsp_write, 1);
    check_val("t2_wr_rsp_rdata", bus.rsp_rdata, 0);
    check_val("t2_wr_rsp_miss", bus.rsp_miss, 0);
    check_val("t2_wr_hit_count", hit_count, 1);
    consume();
    check_val("t2_idle_gap", bus.cpu_read, 0);
    step();
    check_val("t2_rd_cpu_read", bus.cpu_read, 1);
    check_val("t2_rd_cpu_write", bus.cpu_write, 0);
    finish_txn(DATA_5A, 1'b0);
    check_val("t2_rd_rsp_write", bus.rsp_write, 0);
    check_val("t2_rd_rsp_rdata", bus.rsp_rdata, DATA_5A);
    check_val("t2_rd_rsp_miss", bus.rsp_miss, 0);
    check_val("t2_hit_count", hit_count, 2);
    check_val("t2_miss_count", miss_count, 1);
    consume();

    // Fill to full, refused push, ordering, response backpressure
    push(1'b0, 32'h100, '0);
    push(1'b0, 32'h200, '0);
    push(1'b0, 32'h300, '0);
    check_val("t3_ready_3", bus.req_ready, 1);
    push(1'b0, 32'h400, '0);
    check_val("t3_ready_full", bus.req_ready, 0);
    check_val("t3_head_addr", bus.cpu_address, 32'h100);
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_address = 32'h500;
    bus.req_wdata   = '0;
    step();
    check_val("t3_refused_ready", bus.req_ready, 0);
    check_val("t3_head_undisturbed", bus.cpu_address, 32'h100);
    finish_txn(pat(32'h100), 1'b0);
    check_val("t3_ready_after_pop", bus.req_ready, 1);
    check_val("t3_rsp_rdata0", bus.rsp_rdata, pat(32'h100));
    step();
    bus.req_valid = 1'b0;
    check_val("t3_ready_refull", bus.req_ready, 0);
    for (int i = 0; i < 7; i++) begin
      check_val("t3_bp_rsp_valid", bus.rsp_valid, 1);
      check_val("t3_bp_rsp_rdata", bus.rsp_rdata, pat(32'h100));
      check_val("t3_bp_no_read", bus.cpu_read, 0);
      check_val("t3_bp_no_write", bus.cpu_write, 0);
      step();
    end
    check_val("t3_bp_rsp_valid_end", bus.rsp_valid, 1);
    consume();
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t3_order_read", bus.cpu_read, 1);
      check_val("t3_order_addr", bus.cpu_address, fill_addr[i]);
      finish_txn(pat(fill_addr[i]), 1'b0);
      check_val("t3_order_rdata", bus.rsp_rdata, pat(fill_addr[i]));
      consume();
    end
    check_val("t3_hit_count", hit_count, 7);
    check_val("t3_drained_ready", bus.req_ready, 1);

    // Reset during ISSUE with three entries queued
    push(1'b0, 32'h600, '0);
    push(1'b0, 32'h700, '0);
    push(1'b0, 32'h800, '0);
    check_val("t4_pre_issue", bus.cpu_read, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t4_cpu_read", bus.cpu_read, 0);
    check_val("t4_cpu_address", bus.cpu_address, 0);
    check_val("t4_req_ready", bus.req_ready, 1);
    check_val("t4_hit_count", hit_count, 0);
    check_val("t4_miss_count", miss_count, 0);
    check_val("t4_rsp_valid", bus.rsp_valid, 0);
    step();
    step();
    check_val("t4_queue_discarded", bus.cpu_read, 0);
    push(1'b0, 32'h80, '0);
    step();
    check_val("t4_new_read", bus.cpu_read, 1);
    check_val("t4_new_addr", bus.cpu_address, 32'h80);
    finish_txn(pat(32'h80), 1'b1);
    check_val("t4_new_rdata", bus.rsp_rdata, pat(32'h80));
    check_val("t4_new_miss", bus.rsp_miss, 1);
    check_val("t4_new_miss_count", miss_count, 1);
    consume();

    // Saturation: 16 hits into a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 32'h1000 + 32'(i * 64), '0);
      step();
      finish_txn(pat(32'h1000 + 32'(i * 64)), 1'b0);
      consume();
    end
    check_val("t5_hit_count", hit_count, 16);
    check_val("t5_sat_hit_count", sat_hit_count, 4'hF);
    check_val("t5_sat_miss_count", sat_miss_count, 1);
    check_val("t5_miss_count", miss_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_request_queue.md
# cpu_request_queue

Request buffer between the CPU-side requester and the cache subsystem top level (controller, cache, RAM model). It accepts read/write requests over a valid/ready handshake into a small FIFO and issues them one at a time on the subsystem's cpu_read/cpu_write/cpu_address/cpu_write_data inputs. It waits for done_signal, then returns read data plus a hit/miss flag over a valid/ready response channel. It also keeps saturating hit and miss counters.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 512, line data width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  FIFO can accept (= !full)
- req_write  input  1  1 = write, 0 = read
- req_address  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data (ignored for reads)
- cpu_read  output  1  read command to cache subsystem
- cpu_write  output  1  write command to cache subsystem
- cpu_address  output  ADDR_W  head-entry address
- cpu_write_data  output  DATA_W  head-entry write data
- cpu_read_data  input  DATA_W  subsystem read data, valid when done_signal=1
- cache_hit  input  1  subsystem hit indication
- cache_miss  input  1  subsystem miss indication
- done_signal  input  1  one-cycle completion pulse
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_write  output  1  completed op was a write
- rsp_rdata  output  DATA_W  captured read data (0 for writes)
- rsp_miss  output  1  cache_miss seen during the transaction
- hit_count  output  16  completed transactions without a miss, saturating
- miss_count  output  16  completed transactions with a miss, saturating

## Operation
- FIFO: entry = {write, address, wdata}. Push on req_valid && req_ready. Pop when the ISSUE state sees done_signal. req_ready = !full. A push is refused when full even if a pop happens the same cycle. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if count>0 → ISSUE, otherwise stay.
  - ISSUE: cpu_read = !head.write, cpu_write = head.write, cpu_address/cpu_write_data = head fields. All are held constant until done_signal. Any cycle with cache_miss=1 sets the sticky miss flag. On done_signal: capture cpu_read_data into rsp_rdata (reads) or 0 (writes); rsp_miss = sticky | cache_miss; rsp_write = head.write; pop; increment hit_count or miss_count (saturate at 0xFFFF); clear sticky; → RESP.
  - RESP: rsp_valid=1, response fields stable. On rsp_ready → IDLE.
- Outside ISSUE: cpu_read=cpu_write=0, cpu_address/cpu_write_data=0. done_signal, cache_hit and cache_miss are ignored.
- Exactly one transaction is outstanding at a time. No new issue until the response is consumed.

## Timing
- Reset values: req_ready=1, cpu_read=cpu_write=0, cpu_address=0, cpu_write_data=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_miss=0, hit_count=miss_count=0, state IDLE, FIFO empty, sticky miss=0.
- cpu_* outputs decode combinationally from the state register and the FIFO head. rsp_* and the counters are registered.
- Latency for an empty queue:
  - push at edge E0; IDLE sees count=1 in the following cycle.
  - ISSUE entered at E1, so cpu_read/cpu_write are high from E1.
  - done_signal sampled at edge Ed; rsp_valid high from Ed.
  - rsp_ready sampled at Er; IDLE from Er. The next issue starts at Er+1.
- done_signal in the same cycle the command is first asserted is legal and completes the transaction.
- A push while the FIFO is non-empty does not disturb the head or the in-flight command.
- Reset mid-transaction: everything returns to reset values on that edge, queued entries are discarded, and the command drops the next cycle. The subsystem shares rst, so no cleanup handshake is needed.

## Test plan
- Single read, addr 0x0000_0040: push, subsystem raises done after 10 cycles with data 0xA5…A5 and cache_miss=1 → cpu_read high from cycle after push until done; rsp_valid with rsp_rdata=0xA5…A5, rsp_miss=1; miss_count=1.
- Write to 0x40 with data 0x1234, then read 0x40 with a hit → cpu_write then cpu_read issued in order; responses rsp_write=1/rsp_rdata=0, then rsp_write=0/rsp_miss=0; hit_count=2.
- Fill: push 5 requests with DEPTH=4 and done held off → req_ready=0 after the 4th push, 5th refused until the first done; FIFO order preserved on the address bus.
- Response backpressure: rsp_ready held low 8 cycles → rsp fields stable, cpu_read/cpu_write=0 throughout, no second issue until rsp_ready.
- rst asserted during ISSUE with 3 entries queued → next cycle cpu_read=0, req_ready=1, counters 0; a new request afterwards issues normally.
- Counter saturation: force 65537 hit completions → hit_count stays 0xFFFF.
